// File: rtl/note_lane.sv
// One lane of the note highway: a pool of DEPTH falling notes that spawn, fall once per
// frame and are judged against a hit window when the lane key is pressed.
module note_lane #(
  parameter logic [9:0] LANE_X    = 10'd375,
  parameter logic [9:0] NOTE_SIZE = 10'd40,
  parameter logic [9:0] Y_MAX     = 10'd479,
  parameter logic [9:0] Y_STEP    = 10'd3,
  parameter int         DEPTH     = 4,
  parameter logic [9:0] HIT_Y     = 10'd400,
  parameter logic [9:0] HIT_WIN   = 10'd20,
  parameter logic [9:0] MIN_GAP   = 10'd40,
  localparam int        CW        = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_clk,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          spawn,
  input  logic          key_press,
  output logic          is_note,
  output logic          hit_pulse,
  output logic          miss_pulse,
  output logic          ghost_pulse,
  output logic          drop_pulse,
  output logic [CW-1:0] active_count
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [9:0]       y_q [DEPTH];
  logic [9:0]       y_d [DEPTH];
  logic             frame_prev_q, frame_tick_q, frame_tick_d;
  logic             key_prev_q;
  logic             hit_q, hit_d, miss_q, miss_d, ghost_q, ghost_d, drop_q, drop_d;
  logic [CW-1:0]    count_q, count_d;

  logic             key_edge;
  logic [DEPTH-1:0] in_win, y_inside;
  logic             x_inside;

  assign key_edge     = key_press & ~key_prev_q;
  assign frame_tick_d = frame_clk & ~frame_prev_q;

  // All bounds are compared in 11 bits so nothing near the screen bottom wraps.
  assign x_inside = ({1'b0, DrawX} >= {1'b0, LANE_X}) &&
                    ({1'b0, DrawX} <  ({1'b0, LANE_X} + {1'b0, NOTE_SIZE}));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign in_win[gi] = (({1'b0, y_q[gi]} + {1'b0, HIT_WIN}) >= {1'b0, HIT_Y}) &&
                          ({1'b0, y_q[gi]} <= ({1'b0, HIT_Y} + {1'b0, HIT_WIN}));
      assign y_inside[gi] = valid_q[gi] &&
                            ({1'b0, DrawY} >= {1'b0, y_q[gi]}) &&
                            ({1'b0, DrawY} <  ({1'b0, y_q[gi]} + {1'b0, NOTE_SIZE}));
    end
  endgenerate

  assign is_note = x_inside & (|y_inside);

  logic [DEPTH-1:0] hit_sel;
  logic [DEPTH-1:0] free_v;
  logic             hit_found, young_close, spawned;
  logic [9:0]       best_y;
  logic [10:0]      step_sum;

  always_comb begin
    valid_d     = valid_q;
    y_d         = y_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    ghost_d     = 1'b0;
    drop_d      = 1'b0;
    hit_sel     = '0;
    hit_found   = 1'b0;
    best_y      = '0;
    young_close = 1'b0;
    spawned     = 1'b0;
    step_sum    = '0;
    free_v      = '0;
    count_d     = '0;

    // Deepest note in the window wins; strict compare keeps ties on the lowest index.
    if (key_edge) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && in_win[i] && (!hit_found || (y_q[i] > best_y))) begin
          hit_found  = 1'b1;
          best_y     = y_q[i];
          hit_sel    = '0;
          hit_sel[i] = 1'b1;
        end
      end
      if (hit_found) begin
        valid_d = valid_d & ~hit_sel;
        hit_d   = 1'b1;
      end else begin
        ghost_d = 1'b1;
      end
    end

    if (frame_tick_q) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && !hit_sel[i]) begin
          if (y_q[i] > Y_MAX) begin
            valid_d[i] = 1'b0;
            miss_d     = 1'b1;
          end else begin
            step_sum = {1'b0, y_q[i]} + {1'b0, Y_STEP};
            y_d[i]   = step_sum[9:0];
            if (y_q[i] < MIN_GAP) young_close = 1'b1;
          end
        end
      end

      if (spawn) begin
        free_v = ~valid_d;
        for (int i = 0; i < DEPTH; i++) begin
          if (!spawned && !young_close && free_v[i]) begin
            valid_d[i] = 1'b1;
            y_d[i]     = '0;
            spawned    = 1'b1;
          end
        end
        drop_d = ~spawned;
      end
    end

    for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(valid_d[i]);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q      <= '0;
      for (int i = 0; i < DEPTH; i++) y_q[i] <= '0;
      frame_prev_q <= 1'b1;
      frame_tick_q <= 1'b0;
      key_prev_q   <= 1'b1;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      ghost_q      <= 1'b0;
      drop_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      valid_q      <= valid_d;
      y_q          <= y_d;
      frame_prev_q <= frame_clk;
      frame_tick_q <= frame_tick_d;
      key_prev_q   <= key_press;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      ghost_q      <= ghost_d;
      drop_q       <= drop_d;
      count_q      <= count_d;
    end
  end

  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign ghost_pulse  = ghost_q;
  assign drop_pulse   = drop_q;
  assign active_count = count_q;

endmodule
